// File: rtl/dyn_reconf_defs_pkg.sv
// Shared DRP definitions: register addresses, field positions and the
// channel-to-address map used by the reconfiguration register block.
package dyn_reconf_defs;

  localparam int CNT_W = 4;

  localparam logic [6:0] ADDR_CLKFB_REG1 = 7'h14;
  localparam logic [6:0] ADDR_CLKFB_REG2 = 7'h15;
  localparam logic [6:0] ADDR_DIVCLK     = 7'h16;

  localparam int PHASE_MUX_LSB    = 13;
  localparam int HIGH_LSB         = 6;
  localparam int LOW_LSB          = 0;
  localparam int EDGE_BIT         = 7;
  localparam int NO_COUNT_BIT     = 6;
  localparam int DELAY_LSB        = 0;
  localparam int DIV_NO_COUNT_BIT = 12;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } drpState_e;

  // ClkReg1 address of a CLKOUT channel; ClkReg2 sits at the next address.
  function automatic logic [6:0] chanAddr(input int ch);
    case (ch)
      0:       chanAddr = 7'h08;
      1:       chanAddr = 7'h0A;
      2:       chanAddr = 7'h0C;
      3:       chanAddr = 7'h0E;
      4:       chanAddr = 7'h10;
      5:       chanAddr = 7'h06;
      6:       chanAddr = 7'h12;
      default: chanAddr = 7'h7E;
    endcase
  endfunction

endpackage

// File: rtl/dyn_reconf_multi_decode.sv
// Turns one ClkReg1/ClkReg2 pair into divide, duty x1000 and phase in degrees.
module clkreg_decode
  import dyn_reconf_defs::*;
(
  input  logic [15:0] reg1_i,
  input  logic [15:0] reg2_i,
  output logic [31:0] divide_o,
  output logic [31:0] duty_1000_o,
  output logic [31:0] phase_o
);

  logic [31:0] high, low, sum, dutyNum, phaseNum;
  logic        edgeBit, noCount, written;
  logic        unused_bits;

  assign unused_bits = ^{reg1_i[12], reg2_i[15:8]};

  always_comb begin
    high        = 32'(reg1_i[HIGH_LSB +: 6]);
    low         = 32'(reg1_i[LOW_LSB +: 6]);
    sum         = high + low;
    edgeBit     = reg2_i[EDGE_BIT];
    noCount     = reg2_i[NO_COUNT_BIT];
    written     = (reg1_i != 16'h0) || (reg2_i != 16'h0);
    dutyNum     = 32'd2 * high + {31'd0, edgeBit};
    phaseNum    = 32'd8 * 32'(reg2_i[DELAY_LSB +: 6]) + 32'(reg1_i[PHASE_MUX_LSB +: 3]);
    divide_o    = '0;
    duty_1000_o = '0;
    phase_o     = '0;
    // An all-zero pair means "never written", so the consumer sees no override.
    if (written) begin
      if (noCount) begin
        divide_o    = 32'd1;
        duty_1000_o = 32'd500;
        phase_o     = phaseNum * 32'd45;
      end else if (sum == 32'd0) begin
        divide_o    = 32'd1;
        duty_1000_o = 32'd500;
      end else begin
        divide_o    = sum;
        duty_1000_o = (dutyNum * 32'd500) / sum;
        phase_o     = (phaseNum * 32'd45) / sum;
      end
    end
  end

endmodule

// File: rtl/dyn_reconf_multi.sv
// DRP register block for the PLL/MMCM models: handshake FSM with fixed response
// latency, shadow registers and per-channel clock parameter decode.
module dyn_reconf_multi
  import dyn_reconf_defs::*;
#(
  parameter int NUM_CLKOUT   = 7,
  parameter int DRDY_LATENCY = 4
) (
  input  logic                    DCLK,
  input  logic                    RST_N,
  input  logic                    PWRDWN,
  input  logic [6:0]              DADDR,
  input  logic                    DEN,
  input  logic                    DWE,
  input  logic [15:0]             DI,
  output logic [15:0]             DO,
  output logic                    DRDY,
  output logic                    DRP_ERR,
  output logic [32*NUM_CLKOUT-1:0] CLKOUT_DIVIDE,
  output logic [32*NUM_CLKOUT-1:0] CLKOUT_DUTY_CYCLE_1000,
  output logic [32*NUM_CLKOUT-1:0] CLKOUT_PHASE,
  output logic [31:0]             CLKFBOUT_MULT,
  output logic [31:0]             CLKFBOUT_PHASE,
  output logic [31:0]             DIVCLK_DIVIDE
);

  drpState_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [6:0]                addr_q, addr_d;
  logic                      we_q, we_d;
  logic [15:0]               di_q, di_d;
  logic                      drdy_q, drdy_d;
  logic [15:0]               do_q, do_d;
  logic                      err_q, err_d;
  // Index NUM_CLKOUT holds the feedback pair so it shares the decoder array.
  logic [NUM_CLKOUT:0][15:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [15:0]               divReg_q, divReg_d;
  logic [15:0]               rdata;
  logic                      accept;

  always_comb begin
    rdata = '0;
    for (int ch = 0; ch < NUM_CLKOUT; ch++) begin
      if (addr_q == chanAddr(ch))         rdata = reg1_q[ch];
      if (addr_q == chanAddr(ch) + 7'd1)  rdata = reg2_q[ch];
    end
    if (addr_q == ADDR_CLKFB_REG1) rdata = reg1_q[NUM_CLKOUT];
    if (addr_q == ADDR_CLKFB_REG2) rdata = reg2_q[NUM_CLKOUT];
    if (addr_q == ADDR_DIVCLK)     rdata = divReg_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    di_d     = di_q;
    drdy_d   = 1'b0;
    do_d     = '0;
    err_d    = 1'b0;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;
    divReg_d = divReg_q;
    accept   = DEN && !PWRDWN;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = DADDR;
          we_d    = DWE;
          di_d    = DI;
          cnt_d   = CNT_W'(DRDY_LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        err_d = accept;
        if (cnt_q == '0) begin
          state_d = DONE;
          drdy_d  = 1'b1;
          do_d    = we_q ? 16'h0 : rdata;
          // Commit lands on the DRDY edge; unmapped addresses match nothing.
          if (we_q) begin
            for (int ch = 0; ch < NUM_CLKOUT; ch++) begin
              if (addr_q == chanAddr(ch))        reg1_d[ch] = di_q;
              if (addr_q == chanAddr(ch) + 7'd1) reg2_d[ch] = di_q;
            end
            if (addr_q == ADDR_CLKFB_REG1) reg1_d[NUM_CLKOUT] = di_q;
            if (addr_q == ADDR_CLKFB_REG2) reg2_d[NUM_CLKOUT] = di_q;
            if (addr_q == ADDR_DIVCLK)     divReg_d = di_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        err_d   = accept;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      di_q     <= '0;
      drdy_q   <= 1'b0;
      do_q     <= '0;
      err_q    <= 1'b0;
      reg1_q   <= '0;
      reg2_q   <= '0;
      divReg_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      di_q     <= di_d;
      drdy_q   <= drdy_d;
      do_q     <= do_d;
      err_q    <= err_d;
      reg1_q   <= reg1_d;
      reg2_q   <= reg2_d;
      divReg_q <= divReg_d;
    end
  end

  assign DO      = do_q;
  assign DRDY    = drdy_q;
  assign DRP_ERR = err_q;

  logic [NUM_CLKOUT:0][31:0] decDiv, decDuty, decPhase;

  for (genvar g = 0; g <= NUM_CLKOUT; g++) begin : g_dec
    clkreg_decode u_dec (
      .reg1_i      (reg1_q[g]),
      .reg2_i      (reg2_q[g]),
      .divide_o    (decDiv[g]),
      .duty_1000_o (decDuty[g]),
      .phase_o     (decPhase[g])
    );
  end

  assign CLKOUT_DIVIDE          = decDiv[NUM_CLKOUT-1:0];
  assign CLKOUT_DUTY_CYCLE_1000 = decDuty[NUM_CLKOUT-1:0];
  assign CLKOUT_PHASE           = decPhase[NUM_CLKOUT-1:0];
  assign CLKFBOUT_MULT          = decDiv[NUM_CLKOUT];
  assign CLKFBOUT_PHASE         = decPhase[NUM_CLKOUT];

  logic [31:0] divSum;
  logic        unused_bits;

  assign unused_bits = ^{decDuty[NUM_CLKOUT], divReg_q[15:13]};
  assign divSum      = 32'(divReg_q[11:6]) + 32'(divReg_q[5:0]);

  always_comb begin
    DIVCLK_DIVIDE = '0;
    if (divReg_q != 16'h0) begin
      if (divReg_q[DIV_NO_COUNT_BIT] || divSum == 32'd0) DIVCLK_DIVIDE = 32'd1;
      else                                                 DIVCLK_DIVIDE = divSum;
    end
  end

endmodule

// File: doc/dyn_reconf_multi.md
Name: dyn_reconf_multi

Overview:
- Parametrised DRP register block for the PLL/MMCM simulation models. It replaces the fixed six-output reconfiguration unit and serves up to 7 outputs plus feedback and the input divider.
- Implements the DADDR/DEN/DWE/DI/DO/DRDY handshake with a configurable response latency, and adds a protocol-error flag.
- Decodes ClkReg1/ClkReg2 pairs into divide, duty-cycle×1000 and phase-in-degrees values, consumed by the frequency-generator and phase-shift stages.
- Every decoded output reads 0 until its register is written, so the consumer treats 0 as "no dynamic override".

Parameters:
- NUM_CLKOUT, 7, number of CLKOUTn channels decoded (1..7).
- DRDY_LATENCY, 4, DCLK cycles from an accepted DEN to DRDY (1..15).

Ports:
- DCLK  in  1  DRP clock; the only clock.
- RST_N  in  1  asynchronous, active-low reset.
- PWRDWN  in  1  while high, DEN is ignored.
- DADDR  in  7  register address.
- DEN  in  1  transaction strobe, one cycle.
- DWE  in  1  write enable, qualified by DEN.
- DI  in  16  write data.
- DO  out  16  read data; valid only while DRDY is high, 0 otherwise.
- DRDY  out  1  one-cycle completion pulse.
- DRP_ERR  out  1  one-cycle pulse when DEN arrives while busy.
- CLKOUT_DIVIDE  out  32*NUM_CLKOUT  per-channel divide, channel n at [32n+31:32n].
- CLKOUT_DUTY_CYCLE_1000  out  32*NUM_CLKOUT  duty cycle × 1000.
- CLKOUT_PHASE  out  32*NUM_CLKOUT  phase in integer degrees.
- CLKFBOUT_MULT  out  32  feedback multiply.
- CLKFBOUT_PHASE  out  32  feedback phase in degrees.
- DIVCLK_DIVIDE  out  32  input divider.

Behaviour:
- Reset (RST_N low, asynchronous):
  - All shadow registers cleared, which forces every decoded output to 0.
  - DO=0, DRDY=0, DRP_ERR=0, FSM to IDLE.
  - A reset asserted mid-transaction aborts it: no DRDY and no commit.
- Address map:
  - CLKOUT0 0x08/0x09, CLKOUT1 0x0A/0x0B, CLKOUT2 0x0C/0x0D, CLKOUT3 0x0E/0x0F, CLKOUT4 0x10/0x11, CLKOUT5 0x06/0x07, CLKOUT6 0x12/0x13.
  - CLKFBOUT 0x14/0x15; DIVCLK 0x16.
  - Addresses of channels ≥ NUM_CLKOUT, and all other addresses, are unmapped.
- ClkReg1 fields: [15:13] PHASE_MUX, [11:6] HIGH, [5:0] LOW.
- ClkReg2 fields: [7] EDGE, [6] NO_COUNT, [5:0] DELAY.
- DIVCLK register fields: [13] EDGE, [12] NO_COUNT, [11:6] HIGH, [5:0] LOW.
- Decode (combinational from the shadow registers, integer floor, 32-bit):
  - Channel not yet written (both registers zero): all three outputs 0.
  - div = NO_COUNT ? 1 : HIGH+LOW.
  - duty = NO_COUNT ? 500 : (2*HIGH+EDGE)*500/div.
  - phase = (8*DELAY+PHASE_MUX)*45/div.
  - If HIGH+LOW = 0 and NO_COUNT = 0: div = 1, duty = 500, phase = 0. The decode never divides by zero.
  - CLKFBOUT_MULT uses the same divide rule. DIVCLK_DIVIDE likewise, with no phase.
- FSM:
  - IDLE: DEN=1 and PWRDWN=0 latches DADDR/DWE/DI, loads counter = DRDY_LATENCY-1 and goes to BUSY.
  - BUSY: decrements the counter each cycle. When the counter reaches 0 it asserts DRDY for exactly one cycle, the DRDY_LATENCY-th edge after the DEN edge.
  - Commit: a write is committed to its shadow register on the same edge that raises DRDY. Decoded outputs change from that edge on.
  - Reads: DO carries the register value for mapped addresses and 0 for unmapped ones. Writes to unmapped addresses are dropped but still complete with DRDY.
  - Return: back to IDLE on the edge after DRDY.
- Boundary cases:
  - DEN while BUSY, or DEN in the DRDY cycle: ignored, and DRP_ERR pulses one cycle.
  - DEN in the cycle after DRDY is accepted normally.
  - PWRDWN rising mid-transaction does not abort it.
  - DWE without DEN has no effect.

Decomposition:
- Shared package/include file `dyn_reconf_defs`:
  - Address localparams.
  - Field bit positions.
  - Channel-to-address lookup function.
- One sub-module, `clkreg_decode`: (reg1, reg2) → (divide, duty_1000, phase). Instantiated NUM_CLKOUT+1 times via generate; the DIVCLK decode is inline.

Test Plan:
- Reset, then write 0x08=0x0083 and 0x09=0x0000:
  - DRDY exactly 4 cycles after each DEN.
  - CLKOUT_DIVIDE[0]=5, DUTY=400, PHASE=0.
  - Other channels remain 0.
- Write 0x09=0x0080 (EDGE) → DUTY[0]=500. Then write 0x08=0x6083 and 0x09=0x0001 → PHASE[0]=99.
- Write 0x09=0x0040 (NO_COUNT) → DIVIDE[0]=1, DUTY[0]=500.
- Read back 0x08 → DO=0x6083 during the DRDY cycle, DO=0 otherwise. Read 0x7F → DO=0, DRDY still pulses.
- DEN at cycle 0 and again at cycle 2 (latency 4) → a single DRDY at cycle 4, DRP_ERR at cycle 2, and the second write not committed.
- Write 0x16=0x0042 (DIVCLK_DIVIDE=3), then pull RST_N low during a later write's BUSY phase → no DRDY and all outputs 0. With NUM_CLKOUT=2, a write to 0x0C commits nothing.
